// File: rtl/hazard_unit_seq.sv
// Sequential hazard unit: load-use / branch-operand stalls with configurable
// load latency, taken-branch IF/ID flush, debug halt and a saturating
// stall-cycle statistics counter.
module hazard_unit_seq #(
  parameter int NB_REG       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int NB_CNT       = 16,
  parameter int BRANCH_IN_ID = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid_id,
  input  logic [NB_REG-1:0] i_rs,
  input  logic [NB_REG-1:0] i_rt,
  input  logic              i_uses_rt,
  input  logic              i_id_is_branch,
  input  logic [NB_REG-1:0] i_id_ex_wr_reg,
  input  logic              i_id_ex_reg_write,
  input  logic              i_id_ex_mem_read,
  input  logic [NB_REG-1:0] i_ex_mem_wr_reg,
  input  logic              i_ex_mem_mem_read,
  input  logic              i_branch_taken,
  input  logic              i_halt,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_bubble,
  output logic              o_if_id_flush,
  output logic [NB_CNT-1:0] o_stall_count,
  output logic              o_busy
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  // Longest stall is LOAD_LAT+1 = 8; the remaining count after the first
  // stall cycle therefore fits in 3 bits.
  localparam logic [3:0] LL = 4'(LOAD_LAT);

  state_t     state, state_nxt;
  state_t     saved, saved_nxt;
  logic [2:0] rem, rem_nxt;
  logic [3:0] n_req;
  logic       ex_hit, mem_hit, br, count_en;

  // Source/destination match; register 0 and an empty ID slot never hazard.
  always_comb begin
    ex_hit  = i_valid_id && (i_id_ex_wr_reg != '0) &&
              ((i_rs == i_id_ex_wr_reg) || (i_uses_rt && (i_rt == i_id_ex_wr_reg)));
    mem_hit = i_valid_id && (i_ex_mem_wr_reg != '0) &&
              ((i_rs == i_ex_mem_wr_reg) || (i_uses_rt && (i_rt == i_ex_mem_wr_reg)));
    br      = i_id_is_branch && (BRANCH_IN_ID != 0);
  end

  // Required stall length: maximum over all hazard conditions that apply.
  always_comb begin
    n_req = 4'd0;
    if (!br && ex_hit && i_id_ex_mem_read) n_req = LL;
    if (br) begin
      if (ex_hit && i_id_ex_reg_write && !i_id_ex_mem_read && n_req < 4'd1) n_req = 4'd1;
      if (mem_hit && i_ex_mem_mem_read && n_req < LL) n_req = LL;
      if (ex_hit && i_id_ex_mem_read && n_req < LL + 4'd1) n_req = LL + 4'd1;
    end
  end

  // Next-state and output decode; reset forces the safe output pattern.
  always_comb begin
    state_nxt     = state;
    saved_nxt     = saved;
    rem_nxt       = rem;
    count_en      = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_bubble      = 1'b1;
    o_if_id_flush = 1'b0;
    o_busy        = 1'b0;
    case (state)
      RUN: begin
        if (i_halt) begin
          state_nxt = HALT;
          saved_nxt = RUN;
        end else if (n_req != 4'd0) begin
          count_en = 1'b1;
          if (n_req > 4'd1) begin
            state_nxt = STALL;
            rem_nxt   = 3'(n_req - 4'd1);
          end
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_bubble      = 1'b0;
          o_if_id_flush = i_branch_taken && i_valid_id;
        end
      end
      STALL: begin
        o_busy = 1'b1;
        if (i_halt) begin
          state_nxt = HALT;
          saved_nxt = STALL;
        end else begin
          count_en = 1'b1;
          rem_nxt  = rem - 3'd1;
          if (rem == 3'd1) state_nxt = RUN;
        end
      end
      HALT: begin
        o_busy = 1'b1;
        if (!i_halt) state_nxt = saved;
      end
      default: state_nxt = RUN;
    endcase
    if (i_reset) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_bubble      = 1'b1;
      o_if_id_flush = 1'b0;
      o_busy        = 1'b0;
    end
  end

  // State, saved pre-halt state and remaining-stall registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= RUN;
      saved <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      rem   <= rem_nxt;
    end
  end

  // Saturating count of hazard stall cycles (halt cycles excluded).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              o_stall_count <= '0;
    else if (count_en && o_stall_count != '1) o_stall_count <= o_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_unit_seq.sv
// Bench for hazard_unit_seq: two instances (LOAD_LAT=3/NB_CNT=16 and
// LOAD_LAT=1/NB_CNT=4) share one stimulus stream; expected outputs per row
// are hand-derived constants routed through a scoreboard queue.
module tb_hazard_unit_seq;

  typedef struct packed {
    logic       rst, valid;
    logic [4:0] rs, rt;
    logic       uses_rt, br;
    logic [4:0] exwr;
    logic       exrw, exmr;
    logic [4:0] memwr;
    logic       memmr, taken, halt;
  } in_t;

  // ea/eb = {pc_write, bubble, flush, busy} for instance A / B; counts -1 = skip
  typedef struct {
    in_t        in;
    logic [3:0] ea, eb;
    int         ca, cb;
  } vec_t;

  localparam logic [3:0] RN = 4'b1000, FL = 4'b1010, S0 = 4'b0100, S1 = 4'b0101;

  logic clk = 0;
  logic rst, valid, uses_rt, br, exrw, exmr, memmr, taken, halt;
  logic [4:0] rs, rt, exwr, memwr;
  logic pcw_a, ifw_a, bub_a, fl_a, busy_a, pcw_b, ifw_b, bub_b, fl_b, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_chk = 0, n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  hazard_unit_seq #(.NB_REG(5), .LOAD_LAT(3), .NB_CNT(16), .BRANCH_IN_ID(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid_id(valid), .i_rs(rs), .i_rt(rt),
    .i_uses_rt(uses_rt), .i_id_is_branch(br), .i_id_ex_wr_reg(exwr),
    .i_id_ex_reg_write(exrw), .i_id_ex_mem_read(exmr), .i_ex_mem_wr_reg(memwr),
    .i_ex_mem_mem_read(memmr), .i_branch_taken(taken), .i_halt(halt),
    .o_pc_write(pcw_a), .o_if_id_write(ifw_a), .o_bubble(bub_a),
    .o_if_id_flush(fl_a), .o_stall_count(cnt_a), .o_busy(busy_a));

  hazard_unit_seq #(.NB_REG(5), .LOAD_LAT(1), .NB_CNT(4), .BRANCH_IN_ID(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid_id(valid), .i_rs(rs), .i_rt(rt),
    .i_uses_rt(uses_rt), .i_id_is_branch(br), .i_id_ex_wr_reg(exwr),
    .i_id_ex_reg_write(exrw), .i_id_ex_mem_read(exmr), .i_ex_mem_wr_reg(memwr),
    .i_ex_mem_mem_read(memmr), .i_branch_taken(taken), .i_halt(halt),
    .o_pc_write(pcw_b), .o_if_id_write(ifw_b), .o_bubble(bub_b),
    .o_if_id_flush(fl_b), .o_stall_count(cnt_b), .o_busy(busy_b));

  function automatic in_t mk(logic v, int s, int t, logic ur, logic b, int ew, logic erw,
                             logic emr, int mw, logic mmr, logic tk, logic h);
    in_t r;
    r.rst = 1'b0; r.valid = v; r.rs = 5'(s); r.rt = 5'(t); r.uses_rt = ur; r.br = b;
    r.exwr = 5'(ew); r.exrw = erw; r.exmr = emr; r.memwr = 5'(mw); r.memmr = mmr;
    r.taken = tk; r.halt = h;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(in_t in, logic [3:0] ea, logic [3:0] eb, int ca, int cb);
    vec_t v;
    v.in = in; v.ea = ea; v.eb = eb; v.ca = ca; v.cb = cb;
    tbl.push_back(v);
  endtask

  // Drive one cycle, queue its expectation, check at the falling edge.
  task automatic step(string tag, in_t in, logic [3:0] ea, logic [3:0] eb, int ca, int cb);
    vec_t v;
    rst = in.rst; valid = in.valid; rs = in.rs; rt = in.rt; uses_rt = in.uses_rt;
    br = in.br; exwr = in.exwr; exrw = in.exrw; exmr = in.exmr; memwr = in.memwr;
    memmr = in.memmr; taken = in.taken; halt = in.halt;
    v.in = in; v.ea = ea; v.eb = eb; v.ca = ca; v.cb = cb;
    sb.push_back(v);
    @(negedge clk);
    v = sb.pop_front();
    chk({tag, " A pc_write"},    int'(pcw_a),  int'(v.ea[3]));
    chk({tag, " A if_id_write"}, int'(ifw_a),  int'(v.ea[3]));
    chk({tag, " A bubble"},      int'(bub_a),  int'(v.ea[2]));
    chk({tag, " A flush"},       int'(fl_a),   int'(v.ea[1]));
    chk({tag, " A busy"},        int'(busy_a), int'(v.ea[0]));
    chk({tag, " B pc_write"},    int'(pcw_b),  int'(v.eb[3]));
    chk({tag, " B if_id_write"}, int'(ifw_b),  int'(v.eb[3]));
    chk({tag, " B bubble"},      int'(bub_b),  int'(v.eb[2]));
    chk({tag, " B flush"},       int'(fl_b),   int'(v.eb[1]));
    chk({tag, " B busy"},        int'(busy_b), int'(v.eb[0]));
    if (v.ca >= 0) chk({tag, " A stall_count"}, int'(cnt_a), v.ca);
    if (v.cb >= 0) chk({tag, " B stall_count"}, int'(cnt_b), v.cb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t ind, ind_h, lu, rs_in;
    ind   = mk(1, 1, 2, 1, 0, 3, 1, 0, 4, 0, 0, 0);
    ind_h = ind; ind_h.halt = 1'b1;
    lu    = mk(1, 5, 2, 1, 0, 5, 1, 1, 4, 0, 0, 0);
    rs_in = ind; rs_in.rst = 1'b1;

    add(ind, RN, RN, 0, 0);                                    // independent
    add(lu,  S0, S0, 0, 0);                                    // load-use
    add(ind, S1, RN, 1, 1);
    add(ind, S1, RN, 2, 1);
    add(ind, RN, RN, 3, 1);
    add(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0), RN, RN, -1, -1);  // $0 never hazards
    add(mk(1, 1, 5, 0, 0, 5, 1, 1, 4, 0, 0, 0), RN, RN, -1, -1);  // rt not read
    add(mk(0, 5, 2, 1, 0, 5, 1, 1, 4, 0, 0, 0), RN, RN, -1, -1);  // ID invalid
    add(mk(1, 7, 8, 1, 1, 7, 1, 0, 4, 0, 0, 0), S0, S0, -1, -1);  // br vs EX ALU
    add(ind, RN, RN, 4, 2);
    add(mk(1, 7, 8, 1, 1, 7, 1, 1, 4, 0, 0, 0), S0, S0, -1, -1);  // br vs EX load
    add(ind, S1, S1, 5, 3);
    add(ind, S1, RN, 6, 4);
    add(ind, S1, RN, 7, 4);
    add(ind, RN, RN, 8, 4);
    add(mk(1, 7, 8, 1, 1, 3, 1, 0, 7, 1, 0, 0), S0, S0, -1, -1);  // br vs MEM load
    add(ind, S1, RN, 9, 5);
    add(ind, S1, RN, 10, 5);
    add(mk(1, 1, 2, 1, 1, 3, 1, 0, 4, 0, 1, 0), FL, FL, 11, 5);   // taken, no hazard
    add(ind, RN, RN, -1, -1);
    add(mk(1, 7, 8, 1, 1, 7, 1, 0, 4, 0, 1, 0), S0, S0, 11, 5);   // taken during stall
    add(mk(1, 7, 8, 1, 1, 3, 1, 0, 4, 0, 1, 0), FL, FL, 12, 6);
    add(mk(1, 7, 9, 1, 1, 7, 1, 0, 9, 1, 0, 0), S0, S0, 12, 6);   // max of conditions
    add(ind, S1, RN, 13, 7);
    add(ind, S1, RN, 14, 7);
    add(lu,  S0, S0, 15, 7);                                   // A -> STALL rem=2
    add(ind_h, S1, S0, 16, 8);                                 // halt seen
    add(ind_h, S1, S1, 16, 8);
    add(ind_h, S1, S1, 16, 8);
    add(ind_h, S1, S1, 16, 8);
    add(ind, S1, S1, 16, 8);                                   // last HALT cycle
    add(ind, S1, RN, 16, 8);
    add(ind, S1, RN, 17, 8);
    add(ind, RN, RN, 18, 8);
    add(mk(0, 1, 2, 1, 1, 3, 1, 0, 4, 0, 1, 0), RN, RN, -1, -1);  // taken but invalid

    step("reset", rs_in, S0, S0, 0, 0);
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("row%0d", i), tbl[i].in, tbl[i].ea, tbl[i].eb, tbl[i].ca, tbl[i].cb);

    // back-to-back load-use: B saturates at 15, A keeps counting
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), lu, (i % 3 != 0) ? S1 : S0, S0, -1, -1);
    step("sat_end", ind, S1, RN, 38, 15);
    step("sat_run", ind, RN, RN, 39, 15);

    // reset in the middle of a stall
    step("pre_rst", lu, S0, S0, 39, 15);
    step("mid_rst", rs_in, S0, S0, 0, 0);
    step("post_rst", ind, RN, RN, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_unit_seq.md
Name: hazard_unit_seq

Overview:
- Sequential, parametrised successor to the combinational load-use stall detector.
- Sits between the ID stage and the IF/ID, PC and ID/EX control path.
- Covers load-use stalls with configurable memory latency, branch-in-ID data hazards, taken-branch IF/ID flush, debug halt and a saturating stall-cycle counter.
- Outputs are active-high "enable/act" signals: 1 = advance / insert bubble / flush.

Parameters:
- NB_REG, 5: register-address width.
- LOAD_LAT, 1: load-use stall cycles (legal 1..7).
- NB_CNT, 16: width of the stall statistics counter.
- BRANCH_IN_ID, 1: 1 = branches resolve in ID, so branch-operand hazards are checked; 0 = branch checks disabled.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid_id  in  1  ID holds a valid instruction.
- i_rs  in  NB_REG  ID source register rs.
- i_rt  in  NB_REG  ID source register rt.
- i_uses_rt  in  1  ID instruction reads rt.
- i_id_is_branch  in  1  ID instruction is a conditional branch.
- i_id_ex_wr_reg  in  NB_REG  destination register of the instruction in EX.
- i_id_ex_reg_write  in  1  EX instruction writes a register.
- i_id_ex_mem_read  in  1  EX instruction is a load.
- i_ex_mem_wr_reg  in  NB_REG  destination register of the instruction in MEM.
- i_ex_mem_mem_read  in  1  MEM instruction is a load.
- i_branch_taken  in  1  branch in ID resolved taken.
- i_halt  in  1  debug halt request, level.
- o_pc_write  out  1  1 = PC updates.
- o_if_id_write  out  1  1 = IF/ID latches.
- o_bubble  out  1  1 = zero ID/EX control fields.
- o_if_id_flush  out  1  1 = clear IF/ID on the next edge.
- o_stall_count  out  NB_CNT  saturating count of hazard stall cycles.
- o_busy  out  1  1 = FSM is not in RUN.

Behaviour:
- Reset (async, active-high):
  - state = RUN, remaining-stall counter = 0, o_stall_count = 0.
  - While i_reset = 1: o_pc_write = 0, o_if_id_write = 0, o_bubble = 1, o_if_id_flush = 0, o_busy = 0.
- Match rule: a source matches a destination only when the source is read (rs is always read; rt only if i_uses_rt), the addresses are equal, and the destination is non-zero. Register 0 never causes a hazard. i_valid_id = 0 means no hazard.
- Required stall length N, evaluated only in RUN:
  - Load in EX matches, non-branch ID instruction: N = LOAD_LAT.
  - Branch (BRANCH_IN_ID = 1) and EX non-load writer matches: N = 1.
  - Branch and EX load matches: N = LOAD_LAT + 1.
  - Branch and MEM load matches: N = LOAD_LAT.
  - Several conditions true at once: take the maximum N.
- FSM states:
  - RUN:
    - If N > 0: this cycle is stall cycle 1 (combinational). If N > 1, go to STALL with counter = N - 1.
    - If N = 0: o_pc_write = 1, o_if_id_write = 1, o_bubble = 0.
  - STALL:
    - Stall outputs are held. Hazard inputs are ignored.
    - The counter decrements each cycle. When counter = 1 the cycle still stalls and the next state is RUN, where hazards are re-evaluated.
  - HALT:
    - o_pc_write = 0, o_if_id_write = 0, o_bubble = 1.
    - The counter is frozen. The state before the halt (RUN or STALL) is saved.
    - On i_halt = 0, return to the saved state on the next edge.
- Stall cycle outputs: o_pc_write = 0, o_if_id_write = 0, o_bubble = 1.
- Priority: reset > halt > hazard stall > flush.
  - i_halt = 1 enters HALT on the next edge. The cycle in which i_halt is first seen already produces halt outputs (combinational).
- Flush: o_if_id_flush = i_branch_taken & i_valid_id, only in RUN with N = 0 and no halt. Otherwise 0.
- o_stall_count: +1 on each hazard stall cycle (RUN with N > 0, or STALL). Halt cycles are not counted. Saturates at 2^NB_CNT - 1 with no wrap.
- o_busy = 1 in STALL or HALT.
- No combinational path from any output back to any input.

Test Plan:
- Reset, then independent instructions (LOAD_LAT = 1) -> o_pc_write = 1, o_if_id_write = 1, o_bubble = 0, o_stall_count = 0.
- LOAD_LAT = 3; EX lw $5; ID add reads rs = $5 -> exactly 3 stall cycles, o_busy = 1 for 2 cycles, o_stall_count = 3; ID rs = $0 with dest $0 -> 0 stalls.
- Branch in ID, rs = $7: (a) EX ALU writes $7 -> 1 stall; (b) EX lw $7 with LOAD_LAT = 1 -> 2 stalls; (c) MEM lw $7 -> 1 stall.
- Taken branch with no hazard -> o_if_id_flush = 1 for 1 cycle; taken branch during a stall -> o_if_id_flush = 0 until the stall ends.
- i_halt asserted in STALL with counter = 2 for 4 cycles -> held in HALT with o_stall_count frozen; after release -> 2 more stall cycles, then RUN.
- NB_CNT = 4 with 20 back-to-back load-use stalls -> o_stall_count saturates at 15; i_reset asserted mid-STALL -> outputs go immediately to reset values and state = RUN.
